// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: commands queue in a small FIFO,
// each runs one bus cycle, and its result (read data or timeout) is handed back.
module wb_host_master #(
  parameter int          CMD_DEPTH = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_we,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  localparam int          AW       = $clog2(CMD_DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  cmd_t        fifo [CMD_DEPTH];
  cmd_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push;
  state_t      state;
  logic [15:0] tmo_cnt;

  // Extra wrap bit on each pointer separates full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tmo_cnt   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      rsp_we    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      case (state)
        IDLE: begin
          if (!empty) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            wbm_we_o  <= head.we;
            wbm_adr_o <= head.adr;
            wbm_dat_o <= head.dat;
            wbm_sel_o <= head.sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tmo_cnt   <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // ACK on the timeout edge still counts as a normal completion.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_we    <= wbm_we_o;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_we    <= wbm_we_o;
            rsp_dat   <= ERR_DATA;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: scripted commands against a small Wishbone slave model,
// responses checked through an expected-response queue.
module tb_wb_host_master;

  localparam int TMO = 16;

  logic        clk;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_we;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        busy;

  wb_host_master #(.CMD_DEPTH(4), .TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_we(rsp_we),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] bus_adr_q[$];
  int          win_q[$];
  int          checks = 0;
  int          failures = 0;

  // Slave model controls
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  logic        spur_ack = 1'b0;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = '0;
  int          stb_cnt = 0;

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave: ack in the (ack_delay+1)-th cycle of a strobe window.
  always @(negedge clk) begin
    if (wbm_stb_o) begin
      wbm_ack_i = spur_ack | (ack_en && stb_cnt == ack_delay);
      wbm_dat_i = rd_fixed_en ? rd_fixed : slv_data(wbm_adr_o);
      stb_cnt++;
    end else begin
      wbm_ack_i = spur_ack;
      wbm_dat_i = '0;
      stb_cnt = 0;
    end
  end

  // Bus monitor: address at each strobe start, length of each strobe window.
  logic stb_q = 1'b0;
  int   win_len = 0;
  always @(negedge clk) begin
    if (wbm_stb_o && !stb_q) bus_adr_q.push_back(wbm_adr_o);
    if (wbm_stb_o) win_len++;
    else if (stb_q) begin
      win_q.push_back(win_len);
      win_len = 0;
    end
    stb_q = wbm_stb_o;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] edat, input logic eerr);
    int   n = 0;
    rsp_t e;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    e.we = we; e.err = eerr; e.dat = edat;
    exp_q.push_back(e);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL send_cmd_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm);
    int   n = 0;
    rsp_t e;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL %s: no response, rsp_valid=%0b required 1", nm, rsp_valid);
    end else if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected response dat=%h required none", nm, rsp_dat);
    end else begin
      e = exp_q.pop_front();
      if (rsp_we !== e.we || rsp_err !== e.err || rsp_dat !== e.dat) begin
        failures++;
        $display("FAIL %s: got we=%0b err=%0b dat=%h required we=%0b err=%0b dat=%h",
                 nm, rsp_we, rsp_err, rsp_dat, e.we, e.err, e.dat);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
        busy !== 1'b0 || wbm_adr_o !== 32'h0 || rsp_dat !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%0b rv=%0b cyc=%0b stb=%0b busy=%0b adr=%h rdat=%h required 1 0 0 0 0 0 0",
               cmd_ready, rsp_valid, wbm_cyc_o, wbm_stb_o, busy, wbm_adr_o, rsp_dat);
    end
    wb_rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b cyc=%0b required 0 0", busy, wbm_cyc_o);
    end
  endtask

  task automatic test_write();
    win_q.delete();
    ack_en = 1'b1; ack_delay = 2; rd_fixed_en = 1'b0;
    send_cmd(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF, 32'h0, 1'b0);
    checks++;
    if (wbm_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL write_latency_early: cyc=%0b required 0", wbm_cyc_o);
    end
    @(negedge clk);
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 ||
        wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'h0000_00A5 || wbm_sel_o !== 4'hF) begin
      failures++;
      $display("FAIL write_bus: cyc=%0b stb=%0b we=%0b adr=%h dat=%h sel=%h required 1 1 1 30000004 000000a5 f",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    get_rsp("write_rsp");
    checks++;
    if (win_q.size() != 1 || win_q[0] != 3) begin
      failures++;
      $display("FAIL write_window: windows=%0d first=%0d required 1 window of 3",
               win_q.size(), win_q.size() > 0 ? win_q[0] : -1);
    end
  endtask

  task automatic test_read();
    win_q.delete();
    ack_en = 1'b1; ack_delay = 0; rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    @(negedge clk);
    checks++;
    if (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h3000_0008) begin
      failures++;
      $display("FAIL read_bus: stb=%0b we=%0b adr=%h required 1 0 30000008",
               wbm_stb_o, wbm_we_o, wbm_adr_o);
    end
    get_rsp("read_rsp");
    checks++;
    if (win_q.size() != 1 || win_q[0] != 1) begin
      failures++;
      $display("FAIL read_window: windows=%0d first=%0d required 1 window of 1",
               win_q.size(), win_q.size() > 0 ? win_q[0] : -1);
    end
    rd_fixed_en = 1'b0;
  endtask

  task automatic test_timeout();
    win_q.delete();
    ack_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    get_rsp("timeout_rsp");
    checks++;
    if (win_q.size() != 1 || win_q[0] != TMO) begin
      failures++;
      $display("FAIL timeout_window: windows=%0d first=%0d required 1 window of %0d",
               win_q.size(), win_q.size() > 0 ? win_q[0] : -1, TMO);
    end
    win_q.delete();
    ack_en = 1'b1; ack_delay = TMO - 1;
    send_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, slv_data(32'h3000_0014), 1'b0);
    get_rsp("ack_on_timeout_rsp");
    checks++;
    if (win_q.size() != 1 || win_q[0] != TMO) begin
      failures++;
      $display("FAIL ack_on_timeout_window: windows=%0d first=%0d required 1 window of %0d",
               win_q.size(), win_q.size() > 0 ? win_q[0] : -1, TMO);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [5];
    rsp_t        e;
    bus_adr_q.delete();
    ack_en = 1'b1; ack_delay = 3; rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adrs[i]   = 32'h4000_0000 + 32'(i * 16);
      cmd_valid = 1'b1; cmd_we = (i % 2 == 0); cmd_adr = adrs[i];
      cmd_dat   = 32'hC0DE_0000 | 32'(i); cmd_sel = 4'hF;
      e.we = cmd_we; e.err = 1'b0; e.dat = cmd_we ? 32'h0 : slv_data(adrs[i]);
      exp_q.push_back(e);
      checks++;
      if (cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d: cmd_ready=%0b required 1", i, cmd_ready);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_full: cmd_ready=%0b busy=%0b required 0 1", cmd_ready, busy);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) get_rsp($sformatf("b2b_rsp_%0d", i));
    checks++;
    if (bus_adr_q.size() != 5) begin
      failures++;
      $display("FAIL b2b_bus_count: cycles=%0d required 5", bus_adr_q.size());
    end
    for (int i = 0; i < 5 && i < bus_adr_q.size(); i++) begin
      checks++;
      if (bus_adr_q[i] !== adrs[i]) begin
        failures++;
        $display("FAIL b2b_order_%0d: adr=%h required %h", i, bus_adr_q[i], adrs[i]);
      end
    end
  endtask

  task automatic test_rsp_hold();
    rsp_t e;
    int   n = 0;
    ack_en = 1'b1; ack_delay = 1; rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h5000_0020, 32'h0, 4'h3, slv_data(32'h5000_0020), 1'b0);
    send_cmd(1'b0, 32'h5000_0024, 32'h0, 4'hC, slv_data(32'h5000_0024), 1'b0);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== e.dat || rsp_err !== e.err || wbm_stb_o !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle_%0d: rv=%0b dat=%h err=%0b stb=%0b required 1 %h %0b 0",
                 c, rsp_valid, rsp_dat, rsp_err, wbm_stb_o, e.dat, e.err);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || wbm_stb_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: rv=%0b stb=%0b required 0 0", rsp_valid, wbm_stb_o);
    end
    @(negedge clk);
    checks++;
    if (wbm_stb_o !== 1'b1 || wbm_adr_o !== 32'h5000_0024 || wbm_sel_o !== 4'hC) begin
      failures++;
      $display("FAIL hold_next_start: stb=%0b adr=%h sel=%h required 1 50000024 c",
               wbm_stb_o, wbm_adr_o, wbm_sel_o);
    end
    get_rsp("hold_second_rsp");
  endtask

  task automatic test_reset_mid();
    logic active = 1'b0;
    ack_en = 1'b0; rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h6000_0000, 32'h1, 4'hF, 32'h0, 1'b0);
    send_cmd(1'b1, 32'h6000_0004, 32'h2, 4'hF, 32'h0, 1'b0);
    send_cmd(1'b1, 32'h6000_0008, 32'h3, 4'hF, 32'h0, 1'b0);
    checks++;
    if (wbm_stb_o !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: stb=%0b busy=%0b required 1 1", wbm_stb_o, busy);
    end
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 ||
        cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: cyc=%0b stb=%0b rv=%0b ready=%0b busy=%0b required 0 0 0 1 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy);
    end
    exp_q.delete();
    spur_ack = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (wbm_cyc_o || wbm_stb_o || rsp_valid || busy) active = 1'b1;
      @(negedge clk);
    end
    spur_ack = 1'b0;
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: activity=%0b required 0", active);
    end
  endtask

  initial begin
    clk = 1'b0; wb_rst_i = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
